// File: rtl/maxpool2x2_stream_pkg.sv
// -----------------------------------------------------------------------------
// maxpool2x2_stream_pkg
// Shared nn package: default pixel width and feature-map geometry used by the
// conv units and the 2x2 max-pool stage, plus a helper that sizes counters.
// -----------------------------------------------------------------------------
package maxpool2x2_stream_pkg;

  localparam int unsigned NN_N     = 16;  // pixel data width
  localparam int unsigned NN_IMG_W = 28;  // feature-map width  (even, >= 2)
  localparam int unsigned NN_IMG_H = 28;  // feature-map height (even, >= 2)

  // Bits needed to count 0..depth-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned depth);
    if (depth > 32'd1) begin
      return $clog2(depth);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// -----------------------------------------------------------------------------
// maxpool2x2_stream_if
// Pixel stream into the pool stage and pooled pixel stream out of it.
//   din_vld/din            : raster-order input pixels (no backpressure)
//   dout/dout_vld          : pooled pixel and its one-cycle valid pulse
//   frame_done             : pulses with the last pooled pixel of a frame
// master = upstream/producer view, slave = pool stage view.
// -----------------------------------------------------------------------------
interface maxpool2x2_stream_if #(
  parameter int unsigned N = maxpool2x2_stream_pkg::NN_N
) ();

  logic         din_vld;
  logic [N-1:0] din;
  logic [N-1:0] dout;
  logic         dout_vld;
  logic         frame_done;

  modport master (
    output din_vld,
    output din,
    input  dout,
    input  dout_vld,
    input  frame_done
  );

  modport slave (
    input  din_vld,
    input  din,
    output dout,
    output dout_vld,
    output frame_done
  );

endinterface

// File: rtl/maxpool2x2_stream_line_buf.sv
// -----------------------------------------------------------------------------
// pool_line_buf
// Holds the horizontal maxima of the even row while the odd row streams in.
//   clk    : write clock
//   we     : write enable
//   waddr  : write entry (col>>1)
//   wdata  : horizontal max to store
//   raddr  : read entry (col>>1), combinational read
//   rdata  : stored horizontal max
// Contents are intentionally not reset; every entry is written in an even row
// before it is read in the following odd row.
// -----------------------------------------------------------------------------
module pool_line_buf #(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 14,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem_q [DEPTH];

  // Single write port storage.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// -----------------------------------------------------------------------------
// maxpool2x2_stream
// Streaming 2x2/stride-2 unsigned max-pool over a raster-order feature map.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (discards any partial frame)
//   clear  : synchronous frame abort, wins over a simultaneous din_vld
//   bus    : slave side of maxpool2x2_stream_if (din_vld/din in,
//            dout/dout_vld/frame_done out, all outputs registered)
// Even columns park in a pair register, odd columns form a horizontal max.
// Even rows store that max in a half-width line buffer; odd rows combine it
// with the buffered max and emit one pooled pixel the cycle after.
// IMG_W and IMG_H must be even and >= 2.
// -----------------------------------------------------------------------------
module maxpool2x2_stream
  import maxpool2x2_stream_pkg::*;
#(
  parameter int unsigned N     = NN_N,
  parameter int unsigned IMG_W = NN_IMG_W,
  parameter int unsigned IMG_H = NN_IMG_H
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  maxpool2x2_stream_if.slave    bus
);

  localparam int unsigned CW       = cnt_w(IMG_W);
  localparam int unsigned RW       = cnt_w(IMG_H);
  localparam int unsigned LB_DEPTH = IMG_W / 2;
  localparam int unsigned AW       = cnt_w(LB_DEPTH);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  function automatic logic [N-1:0] umax(input logic [N-1:0] a, input logic [N-1:0] b);
    if (a >= b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  logic [CW-1:0] col_q,        col_d;
  logic [RW-1:0] row_q,        row_d;
  logic [N-1:0]  pair_q,       pair_d;
  logic [N-1:0]  dout_q,       dout_d;
  logic          dout_vld_q,   dout_vld_d;
  logic          frame_done_q, frame_done_d;

  logic          lb_we_s;
  logic [AW-1:0] lb_addr_s;
  logic [N-1:0]  lb_rdata_s;
  logic [N-1:0]  hmax_s;
  logic [N-1:0]  vmax_s;

  // Write and read share col>>1: the even row writes an entry, the odd row reads it.
  assign lb_addr_s = AW'(col_q >> 1'b1);
  assign hmax_s    = umax(pair_q, bus.din);
  assign vmax_s    = umax(hmax_s, lb_rdata_s);

  pool_line_buf #(
    .N     (N),
    .DEPTH (LB_DEPTH),
    .AW    (AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we_s),
    .waddr (lb_addr_s),
    .wdata (hmax_s),
    .raddr (lb_addr_s),
    .rdata (lb_rdata_s)
  );

  // Next-state: raster position, pair/line-buffer updates and pooled output.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    dout_d       = dout_q;
    dout_vld_d   = 1'b0;
    frame_done_d = 1'b0;
    lb_we_s      = 1'b0;

    if (clear) begin
      // Abort drops the coincident pixel; line buffer contents become don't-care.
      col_d  = {CW{1'b0}};
      row_d  = {RW{1'b0}};
      pair_d = {N{1'b0}};
    end else if (bus.din_vld) begin
      if (!col_q[0]) begin
        pair_d = bus.din;
      end else if (!row_q[0]) begin
        lb_we_s = 1'b1;
      end else begin
        dout_d       = vmax_s;
        dout_vld_d   = 1'b1;
        frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end

      if (col_q == COL_LAST) begin
        col_d = {CW{1'b0}};
        if (row_q == ROW_LAST) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = row_q + RW'(1'b1);
        end
      end else begin
        col_d = col_q + CW'(1'b1);
      end
    end else begin
      // Gap cycle: nothing advances, dout keeps its last value.
      col_d = col_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= {CW{1'b0}};
      row_q        <= {RW{1'b0}};
      pair_q       <= {N{1'b0}};
      dout_q       <= {N{1'b0}};
      dout_vld_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_vld   = dout_vld_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// -----------------------------------------------------------------------------
// tb_maxpool2x2_stream
// Directed frames on a 4x4 map. The driver pushes the hand-computed pooled
// value when it issues each odd-row/odd-col pixel; an independent monitor pops
// and checks value, frame_done and one-cycle latency on every dout_vld.
// -----------------------------------------------------------------------------
module tb_maxpool2x2_stream;

  localparam int unsigned N = 16;
  localparam int unsigned W = 4;
  localparam int unsigned H = 4;

  typedef logic [15:0] frame_t [16];
  typedef logic [15:0] exp4_t [4];

  typedef struct {
    logic [15:0] val;
    logic        last;
    int          stamp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  always #5 clk = ~clk;

  maxpool2x2_stream_if #(.N(N)) bus ();

  maxpool2x2_stream #(.N(N), .IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  int   tests    = 0;
  int   fails    = 0;
  int   cyc      = 0;
  int   pix_idx  = 0;
  int   pushed   = 0;
  int   popped   = 0;
  int   fd_exp   = 0;
  int   fd_seen  = 0;
  logic [15:0] last_val = 16'h0000;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every output cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_val = 16'h0000;
      end else if (bus.dout_vld) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: dout=%0h with nothing expected (cycle %0d)", bus.dout, cyc);
        end else begin
          e = sb.pop_front();
          check("dout", {16'h0000, bus.dout}, {16'h0000, e.val});
          check("frame_done", {31'd0, bus.frame_done}, {31'd0, e.last});
          check("latency", cyc, e.stamp + 1);
          last_val = e.val;
          popped++;
          if (bus.frame_done) fd_seen++;
        end
      end else begin
        check("dout_hold", {16'h0000, bus.dout}, {16'h0000, last_val});
        if (bus.frame_done) begin
          tests++;
          fails++;
          $display("FAIL stray_frame_done: got 1 expected 0 without dout_vld (cycle %0d)", cyc);
        end
      end
    end
  end

  task automatic drive_pixel(input logic [15:0] v, input logic [15:0] ev, input int gap);
    int   r;
    int   c;
    exp_t e;
    @(negedge clk);
    bus.din_vld = 1'b1;
    bus.din     = v;
    r = pix_idx / W;
    c = pix_idx % W;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      e.val   = ev;
      e.last  = (pix_idx == W * H - 1);
      e.stamp = cyc;
      sb.push_back(e);
      pushed++;
      if (e.last) fd_exp++;
    end
    pix_idx = (pix_idx + 1) % (W * H);
    repeat (gap) begin
      @(negedge clk);
      bus.din_vld = 1'b0;
      bus.din     = 16'hDEAD;
    end
  endtask

  task automatic run_frame(input frame_t px, input exp4_t ex, input bit gaps);
    int k;
    int g;
    for (int i = 0; i < 16; i++) begin
      k = ((i / W) / 2) * (W / 2) + (i % W) / 2;
      g = gaps ? int'($urandom_range(0, 3)) : 0;
      drive_pixel(px[i], ex[k], g);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.din_vld = 1'b0;
    end
  endtask

  initial begin
    frame_t f_seq, f_mix, f_ext;
    exp4_t  e_seq, e_mix, e_ext;

    f_seq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8,
              16'd9, 16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16};
    e_seq = '{16'd6, 16'd8, 16'd14, 16'd16};
    f_mix = '{16'd9, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd7,
              16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5};
    e_mix = '{16'd9, 16'd7, 16'd5, 16'd5};
    f_ext = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
              16'h0000, 16'h0000, 16'h0000, 16'hFFFE,
              16'h0000, 16'h0000, 16'hFFFF, 16'h0000,
              16'h0000, 16'h8000, 16'h0000, 16'h7FFF};
    e_ext = '{16'hFFFF, 16'hFFFE, 16'h8000, 16'hFFFF};

    rst_n       = 1'b0;
    clear       = 1'b0;
    bus.din_vld = 1'b0;
    bus.din     = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_dout", {16'h0000, bus.dout}, 32'd0);
    check("reset_dout_vld", {31'd0, bus.dout_vld}, 32'd0);
    check("reset_frame_done", {31'd0, bus.frame_done}, 32'd0);
    rst_n = 1'b1;

    // Continuous frame, gapped frame, buffered-row/tie frame, unsigned extremes.
    run_frame(f_seq, e_seq, 1'b0);
    idle(3);
    run_frame(f_seq, e_seq, 1'b1);
    idle(3);
    run_frame(f_mix, e_mix, 1'b0);
    idle(3);
    run_frame(f_ext, e_ext, 1'b1);
    idle(3);

    // Partial frame aborted by rst_n.
    for (int i = 0; i < 6; i++) drive_pixel(16'(100 + i), 16'd105, 0);
    idle(1);
    @(negedge clk);
    rst_n   = 1'b0;
    pix_idx = 0;
    repeat (2) @(negedge clk);
    check("midrst_dout", {16'h0000, bus.dout}, 32'd0);
    check("midrst_dout_vld", {31'd0, bus.dout_vld}, 32'd0);
    rst_n = 1'b1;
    run_frame(f_seq, e_seq, 1'b0);
    idle(3);

    // Partial frame aborted by clear, with a pixel presented on the clear cycle.
    for (int i = 0; i < 6; i++) drive_pixel(16'(200 + i), 16'd205, 0);
    idle(1);
    @(negedge clk);
    clear       = 1'b1;
    bus.din_vld = 1'b1;
    bus.din     = 16'h0999;
    pix_idx     = 0;
    @(negedge clk);
    clear       = 1'b0;
    bus.din_vld = 1'b0;
    check("clear_dout_vld", {31'd0, bus.dout_vld}, 32'd0);
    check("clear_frame_done", {31'd0, bus.frame_done}, 32'd0);
    run_frame(f_seq, e_seq, 1'b0);
    idle(3);

    // Back-to-back frames with no idle cycle in between.
    run_frame(f_seq, e_seq, 1'b0);
    run_frame(f_mix, e_mix, 1'b0);
    idle(5);

    check("pulse_count", popped, pushed);
    check("frame_done_count", fd_seen, fd_exp);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/maxpool2x2_stream.md
MAXPOOL2X2_STREAM -- requirements
Module: maxpool2x2_stream

Interface
REQ-001 Parameter N, default 16: pixel data width in bits.
REQ-002 Parameter IMG_W, default 28: input feature-map width in pixels; SHALL be even and >= 2.
REQ-003 Parameter IMG_H, default 28: input feature-map height in pixels; SHALL be even and >= 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous frame abort, active high.
REQ-007 din_vld  input  1  input pixel valid, active high; driven by the upstream conv unit's output-valid flag.
REQ-008 din  input  N  input pixel: unsigned, post-ReLU conv output.
REQ-009 dout  output  N  pooled pixel.
REQ-010 dout_vld  output  1  pooled pixel valid, one-cycle pulse per pooled pixel.
REQ-011 frame_done  output  1  one-cycle pulse coincident with the last pooled pixel of a frame.

Function
REQ-012 Input pixels SHALL be consumed in raster order (row-major, column 0 first), one pixel per cycle with din_vld=1; cycles with din_vld=0 are gaps and SHALL NOT advance any counter.
REQ-013 col counter: 0..IMG_W-1; increments on each accepted pixel; wraps to 0 and increments row counter at IMG_W-1.
REQ-014 row counter: 0..IMG_H-1; wraps to 0 after last pixel of the frame.
REQ-015 On even col: din SHALL be held in a pair register.
REQ-016 On odd col: hmax = unsigned max(pair register, din).
REQ-017 Even row, odd col: hmax SHALL be written to line buffer entry col>>1 (IMG_W/2 entries of N bits).
REQ-018 Odd row, odd col: dout SHALL be registered as unsigned max(hmax, line buffer[col>>1]); dout_vld=1 the following cycle.
REQ-019 Latency: dout_vld SHALL assert exactly 1 cycle after the accepted odd-row/odd-col pixel, regardless of gaps.
REQ-020 dout SHALL hold its last value when dout_vld=0.
REQ-021 Ties: equal values SHALL yield that value; comparison is unsigned over all N bits.
REQ-022 Output count per frame: exactly (IMG_W/2)*(IMG_H/2) dout_vld pulses.
REQ-023 frame_done SHALL pulse in the same cycle as the dout_vld for pixel (IMG_H-1, IMG_W-1).
REQ-024 Back-to-back frames SHALL be supported with no idle cycle between last pixel of frame k and first pixel of frame k+1.
REQ-025 clear=1: counters and pair register return to 0, dout_vld/frame_done are 0 next cycle; line buffer contents are don't-care; clear has priority over a simultaneous din_vld (that pixel is dropped).
REQ-026 No backpressure: the block SHALL accept a pixel every cycle.

Reset
REQ-027 While rst_n=0: col=0, row=0, pair register=0, dout=0, dout_vld=0, frame_done=0; line buffer not reset.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first pixel after release is treated as (0,0).

Structure
REQ-029 N and the default IMG_W/IMG_H SHALL be defined in the shared nn package used by the conv units; counter widths are derived locally as clog2 of the dimensions.
REQ-030 Line buffer SHALL be a separate sub-module pool_line_buf (IMG_W/2 x N, one write port, one read port, combinational read at col>>1).
REQ-031 Target 150-300 lines RTL total; no multipliers.

Verification (bench IMG_W=4, IMG_H=4, N=16)
REQ-032 Frame 1..16 continuous -> dout 6,8,14,16 in order; frame_done with 16; exactly 4 pulses.
REQ-033 Same frame with din_vld gaps of 0-3 random cycles -> identical dout sequence; each dout_vld exactly 1 cycle after its triggering pixel.
REQ-034 Row0=[9,1,1,1], row1=[0,0,0,7], rows2-3 all 5 -> dout 9,7,5,5 (max from buffered row and ties correct).
REQ-035 Unsigned extremes: a window containing 16'hFFFF and 0 -> dout 16'hFFFF.
REQ-036 rst_n asserted after 6 pixels, then full frame 1..16 -> dout 6,8,14,16, no stale output; same check with clear in place of rst_n, including clear coinciding with din_vld=1.
REQ-037 Two back-to-back frames, no gap -> 8 pulses, two frame_done pulses, second frame values correct.
